// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the write-back queue slice.
// Contents:
//   AW, DW      - register index width and data width
//   REG_ZERO    - the hard-wired zero register; writes to it are dropped
//   wb_entry_t  - one queued write: destination register plus value
package wb_write_queue_pkg;

    localparam int AW = 5;
    localparam int DW = 32;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] regno;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue.
// Groups the two producer handshakes (ALU, memory), the register-file write
// port, the two decode-stage bypass lookups and the empty flag.
//   master : environment side (drives producer offers, hold, lookup indices)
//   slave  : queue side (drives readies, write port, bypass results, empty)
interface wb_write_queue_if #(
    parameter int AW = wb_write_queue_pkg::AW,
    parameter int DW = wb_write_queue_pkg::DW
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;

    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;

    logic          wb_hold;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedata;
    logic          RegWrite;

    logic [AW-1:0] byp_reg1;
    logic          byp_hit1;
    logic [DW-1:0] byp_data1;
    logic [AW-1:0] byp_reg2;
    logic          byp_hit2;
    logic [DW-1:0] byp_data2;

    logic          empty;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output wb_hold, byp_reg1, byp_reg2,
        input  alu_ready, mem_ready,
        input  writereg, writedata, RegWrite,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2,
        input  empty
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  wb_hold, byp_reg1, byp_reg2,
        output alu_ready, mem_ready,
        output writereg, writedata, RegWrite,
        output byp_hit1, byp_data1, byp_hit2, byp_data2,
        output empty
    );

endinterface

// File: rtl/wb_bypass_match.sv
// Youngest-match lookup over the write-back queue.
// Ports:
//   entries - queue storage, indexed by slot
//   valid   - per-slot occupancy mask
//   head    - slot of the oldest entry
//   lookup  - register index requested by decode
//   hit     - some occupied slot targets lookup (never for register 0)
//   data    - value of the youngest such slot, 0 on a miss
module wb_bypass_match
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t     entries [DEPTH],
    input  logic          valid   [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [AW-1:0] lookup,
    output logic          hit,
    output logic [DW-1:0] data
);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the newest value.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (entries[idx].regno == lookup) && (lookup != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue in front of the 32-entry register file.
// Accepts ALU and load results, keeps them in order in a DEPTH-entry circular
// buffer and drains one per cycle onto the register-file write port.
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - synchronous active-low reset; discards every queued entry
//   bus   - wb_write_queue_if.slave: producer handshakes, write port
//           (writereg/writedata/RegWrite), wb_hold, two bypass lookups, empty
// AW/DW must match the package widths, since entries use wb_entry_t.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = wb_write_queue_pkg::AW,
    parameter int DW    = wb_write_queue_pkg::DW
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_write_queue_if.slave bus
);

    import wb_write_queue_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     ent_q [DEPTH];
    logic          vld_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [CW-1:0] free;
    logic          alu_fire;
    logic          mem_fire;
    logic          alu_store;
    logic          mem_store;
    logic [PW-1:0] mem_slot;
    logic          deq;
    logic [CW-1:0] n_add;
    logic [CW-1:0] n_sub;

    // Space comes only from registered state; a same-cycle drain frees nothing
    // until the next cycle.
    assign free = CW'(DEPTH) - count_q;

    assign bus.alu_ready = (free >= CW'(1));
    assign bus.mem_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !bus.alu_valid);

    assign alu_fire = bus.alu_valid && bus.alu_ready;
    assign mem_fire = bus.mem_valid && bus.mem_ready;

    // Register 0 writes complete the handshake but never occupy a slot.
    assign alu_store = alu_fire && (bus.alu_reg != REG_ZERO);
    assign mem_store = mem_fire && (bus.mem_reg != REG_ZERO);

    // ALU result is older; the load lands behind it when both are stored.
    assign mem_slot = tail_q + PW'(alu_store);

    // Gating with rst_n keeps the write port quiet during a reset cycle.
    assign deq = rst_n && (count_q != '0) && !bus.wb_hold;

    assign n_add = CW'(alu_store) + CW'(mem_store);
    assign n_sub = CW'(deq);

    assign bus.RegWrite  = deq;
    assign bus.writereg  = deq ? ent_q[head_q].regno : '0;
    assign bus.writedata = deq ? ent_q[head_q].data  : '0;
    assign bus.empty     = (count_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
            end
        end else begin
            // Slot being drained cannot be a slot being filled: filling head
            // requires an empty queue, and a full queue accepts nothing.
            if (deq) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PW'(1);
            end
            if (alu_store) begin
                vld_q[tail_q] <= 1'b1;
            end
            if (mem_store) begin
                vld_q[mem_slot] <= 1'b1;
            end
            tail_q  <= tail_q + PW'(alu_store) + PW'(mem_store);
            count_q <= count_q + n_add - n_sub;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (alu_store) begin
            ent_q[tail_q] <= '{regno: bus.alu_reg, data: bus.alu_data};
        end
        if (mem_store) begin
            ent_q[mem_slot] <= '{regno: bus.mem_reg, data: bus.mem_data};
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH), .PW(PW)) u_byp1 (
        .entries (ent_q),
        .valid   (vld_q),
        .head    (head_q),
        .lookup  (bus.byp_reg1),
        .hit     (bus.byp_hit1),
        .data    (bus.byp_data1)
    );

    wb_bypass_match #(.DEPTH(DEPTH), .PW(PW)) u_byp2 (
        .entries (ent_q),
        .valid   (vld_q),
        .head    (head_q),
        .lookup  (bus.byp_reg2),
        .hit     (bus.byp_hit2),
        .data    (bus.byp_data2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: inputs change on the falling edge,
// outputs are sampled 1 time unit later, state commits on the rising edge.
module tb_wb_write_queue;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    wb_write_queue_if #(.AW(5), .DW(32)) bif ();

    wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy must stay within 0..DEPTH (an underflow wraps above DEPTH).
    always @(negedge clk) begin
        if (rst_n && (int'(dut.count_q) > 4)) begin
            bad++;
            $display("FAIL count_range: got %0d want <=4", dut.count_q);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bif.alu_valid = 1'b0; bif.alu_reg = '0; bif.alu_data = '0;
        bif.mem_valid = 1'b0; bif.mem_reg = '0; bif.mem_data = '0;
        bif.wb_hold   = 1'b0; bif.byp_reg1 = '0; bif.byp_reg2 = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        bif.byp_reg1 = 5'd5;
        #1;
        total++; if (bif.RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite: got %0h want 0", bif.RegWrite); end
        total++; if (bif.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %0h want 1", bif.empty); end
        total++; if (bif.byp_hit1 !== 1'b0) begin bad++; $display("FAIL reset_hit1: got %0h want 0", bif.byp_hit1); end
        total++; if (bif.byp_data1 !== 32'h0) begin bad++; $display("FAIL reset_data1: got %0h want 0", bif.byp_data1); end
        total++; if (bif.writereg !== 5'd0) begin bad++; $display("FAIL reset_writereg: got %0h want 0", bif.writereg); end
        total++; if (bif.writedata !== 32'h0) begin bad++; $display("FAIL reset_writedata: got %0h want 0", bif.writedata); end
        total++; if (bif.alu_ready !== 1'b1 || bif.mem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0h%0h want 11", bif.alu_ready, bif.mem_ready); end
    endtask

    task automatic test_alu_single();
        idle();
        bif.alu_valid = 1'b1; bif.alu_reg = 5'd3; bif.alu_data = 32'h1E;
        #1;
        total++; if (bif.alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %0h want 1", bif.alu_ready); end
        tick();
        idle();
        bif.byp_reg1 = 5'd3;
        #1;
        total++; if (bif.RegWrite !== 1'b1) begin bad++; $display("FAIL single_regwrite: got %0h want 1", bif.RegWrite); end
        total++; if (bif.writereg !== 5'd3) begin bad++; $display("FAIL single_writereg: got %0h want 3", bif.writereg); end
        total++; if (bif.writedata !== 32'h1E) begin bad++; $display("FAIL single_writedata: got %0h want 1e", bif.writedata); end
        total++; if (bif.byp_hit1 !== 1'b1 || bif.byp_data1 !== 32'h1E) begin bad++; $display("FAIL single_bypass_head: got %0h/%0h want 1/1e", bif.byp_hit1, bif.byp_data1); end
        tick();
        #1;
        total++; if (bif.empty !== 1'b1) begin bad++; $display("FAIL single_empty: got %0h want 1", bif.empty); end
        total++; if (bif.RegWrite !== 1'b0) begin bad++; $display("FAIL single_idle_regwrite: got %0h want 0", bif.RegWrite); end
    endtask

    task automatic test_same_cycle();
        idle();
        bif.wb_hold   = 1'b1;
        bif.alu_valid = 1'b1; bif.alu_reg = 5'd4; bif.alu_data = 32'h28;
        bif.mem_valid = 1'b1; bif.mem_reg = 5'd4; bif.mem_data = 32'h99;
        #1;
        total++; if (bif.alu_ready !== 1'b1 || bif.mem_ready !== 1'b1) begin bad++; $display("FAIL pair_ready: got %0h%0h want 11", bif.alu_ready, bif.mem_ready); end
        tick();
        idle();
        bif.wb_hold  = 1'b1;
        bif.byp_reg1 = 5'd4;
        #1;
        total++; if (bif.byp_hit1 !== 1'b1 || bif.byp_data1 !== 32'h99) begin bad++; $display("FAIL pair_youngest: got %0h/%0h want 1/99", bif.byp_hit1, bif.byp_data1); end
        total++; if (bif.RegWrite !== 1'b0 || bif.writedata !== 32'h0) begin bad++; $display("FAIL pair_hold: got %0h/%0h want 0/0", bif.RegWrite, bif.writedata); end
        bif.wb_hold = 1'b0;
        #1;
        total++; if (bif.RegWrite !== 1'b1 || bif.writereg !== 5'd4 || bif.writedata !== 32'h28) begin bad++; $display("FAIL pair_first: got %0h/%0h/%0h want 1/4/28", bif.RegWrite, bif.writereg, bif.writedata); end
        tick();
        #1;
        total++; if (bif.RegWrite !== 1'b1 || bif.writedata !== 32'h99) begin bad++; $display("FAIL pair_second: got %0h/%0h want 1/99", bif.RegWrite, bif.writedata); end
        total++; if (bif.byp_hit1 !== 1'b1 || bif.byp_data1 !== 32'h99) begin bad++; $display("FAIL pair_bypass_tail: got %0h/%0h want 1/99", bif.byp_hit1, bif.byp_data1); end
        tick();
        #1;
        total++; if (bif.empty !== 1'b1 || bif.byp_hit1 !== 1'b0) begin bad++; $display("FAIL pair_drained: got %0h/%0h want 1/0", bif.empty, bif.byp_hit1); end
    endtask

    task automatic test_full();
        idle();
        bif.wb_hold   = 1'b1;
        bif.alu_valid = 1'b1; bif.alu_reg = 5'd1; bif.alu_data = 32'h11;
        bif.mem_valid = 1'b1; bif.mem_reg = 5'd2; bif.mem_data = 32'h22;
        tick();
        bif.alu_reg = 5'd3; bif.alu_data = 32'h33;
        bif.mem_reg = 5'd5; bif.mem_data = 32'h55;
        #1;
        total++; if (bif.mem_ready !== 1'b1) begin bad++; $display("FAIL full_two_free: got %0h want 1", bif.mem_ready); end
        tick();
        bif.alu_reg = 5'd6; bif.alu_data = 32'h66;
        bif.mem_reg = 5'd7; bif.mem_data = 32'h77;
        #1;
        total++; if (bif.alu_ready !== 1'b0 || bif.mem_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0h%0h want 00", bif.alu_ready, bif.mem_ready); end
        total++; if (bif.RegWrite !== 1'b0) begin bad++; $display("FAIL full_hold: got %0h want 0", bif.RegWrite); end
        bif.wb_hold   = 1'b0;
        bif.mem_valid = 1'b0;
        #1;
        total++; if (bif.RegWrite !== 1'b1 || bif.writedata !== 32'h11) begin bad++; $display("FAIL full_drain_first: got %0h/%0h want 1/11", bif.RegWrite, bif.writedata); end
        total++; if (bif.alu_ready !== 1'b0) begin bad++; $display("FAIL full_no_same_cycle_space: got %0h want 0", bif.alu_ready); end
        tick();
        bif.mem_valid = 1'b1;
        #1;
        total++; if (bif.alu_ready !== 1'b1) begin bad++; $display("FAIL full_space_next: got %0h want 1", bif.alu_ready); end
        total++; if (bif.mem_ready !== 1'b0) begin bad++; $display("FAIL full_mem_yields: got %0h want 0", bif.mem_ready); end
        total++; if (bif.writedata !== 32'h22) begin bad++; $display("FAIL full_drain_second: got %0h want 22", bif.writedata); end
        bif.mem_valid = 1'b0;
        tick();
        idle();
        bif.byp_reg1 = 5'd6;
        #1;
        total++; if (bif.writedata !== 32'h33) begin bad++; $display("FAIL full_drain_third: got %0h want 33", bif.writedata); end
        total++; if (bif.byp_hit1 !== 1'b1 || bif.byp_data1 !== 32'h66) begin bad++; $display("FAIL full_bypass_wrap: got %0h/%0h want 1/66", bif.byp_hit1, bif.byp_data1); end
        tick();
        #1;
        total++; if (bif.writedata !== 32'h55 || bif.writereg !== 5'd5) begin bad++; $display("FAIL full_drain_fourth: got %0h/%0h want 55/5", bif.writedata, bif.writereg); end
        tick();
        #1;
        total++; if (bif.writedata !== 32'h66 || bif.writereg !== 5'd6) begin bad++; $display("FAIL full_drain_fifth: got %0h/%0h want 66/6", bif.writedata, bif.writereg); end
        tick();
        #1;
        total++; if (bif.empty !== 1'b1) begin bad++; $display("FAIL full_empty: got %0h want 1", bif.empty); end
    endtask

    task automatic test_reg_zero();
        idle();
        bif.wb_hold   = 1'b1;
        bif.alu_valid = 1'b1; bif.alu_reg = 5'd7; bif.alu_data = 32'h77;
        tick();
        bif.alu_reg = 5'd0; bif.alu_data = 32'hFFFF;
        #1;
        total++; if (bif.alu_ready !== 1'b1) begin bad++; $display("FAIL r0_ready: got %0h want 1", bif.alu_ready); end
        tick();
        idle();
        bif.wb_hold  = 1'b1;
        bif.byp_reg1 = 5'd0;
        bif.byp_reg2 = 5'd7;
        #1;
        total++; if (bif.byp_hit1 !== 1'b0 || bif.byp_data1 !== 32'h0) begin bad++; $display("FAIL r0_bypass: got %0h/%0h want 0/0", bif.byp_hit1, bif.byp_data1); end
        total++; if (bif.byp_hit2 !== 1'b1 || bif.byp_data2 !== 32'h77) begin bad++; $display("FAIL r0_port2: got %0h/%0h want 1/77", bif.byp_hit2, bif.byp_data2); end
        bif.wb_hold = 1'b0;
        #1;
        total++; if (bif.RegWrite !== 1'b1 || bif.writereg !== 5'd7) begin bad++; $display("FAIL r0_drain: got %0h/%0h want 1/7", bif.RegWrite, bif.writereg); end
        tick();
        #1;
        total++; if (bif.empty !== 1'b1 || bif.RegWrite !== 1'b0) begin bad++; $display("FAIL r0_not_stored: got %0h/%0h want 1/0", bif.empty, bif.RegWrite); end
    endtask

    task automatic test_reset_mid();
        idle();
        bif.wb_hold   = 1'b1;
        bif.alu_valid = 1'b1; bif.alu_reg = 5'd8; bif.alu_data = 32'h80;
        bif.mem_valid = 1'b1; bif.mem_reg = 5'd9; bif.mem_data = 32'h90;
        tick();
        bif.mem_valid = 1'b0;
        bif.alu_reg = 5'd10; bif.alu_data = 32'hA0;
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        total++; if (bif.RegWrite !== 1'b0) begin bad++; $display("FAIL rstmid_no_write: got %0h want 0", bif.RegWrite); end
        tick();
        rst_n = 1'b1;
        bif.byp_reg1 = 5'd8;
        bif.byp_reg2 = 5'd9;
        #1;
        total++; if (bif.empty !== 1'b1 || bif.RegWrite !== 1'b0) begin bad++; $display("FAIL rstmid_empty: got %0h/%0h want 1/0", bif.empty, bif.RegWrite); end
        total++; if (bif.byp_hit1 !== 1'b0 || bif.byp_hit2 !== 1'b0) begin bad++; $display("FAIL rstmid_miss_8_9: got %0h/%0h want 0/0", bif.byp_hit1, bif.byp_hit2); end
        bif.byp_reg1 = 5'd10;
        #1;
        total++; if (bif.byp_hit1 !== 1'b0 || bif.byp_data1 !== 32'h0) begin bad++; $display("FAIL rstmid_miss_10: got %0h/%0h want 0/0", bif.byp_hit1, bif.byp_data1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_alu_single();
        test_same_cycle();
        test_full();
        test_reg_zero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Write-back side initiator for the 32-entry register file.
- Accepts results from two producers, the ALU and the memory/load path, and buffers them in a small in-order queue.
- Drains the queue onto the register file's single write port (writereg/writedata/RegWrite), at most one write per cycle.
- Offers two bypass lookup ports so the decode stage can read values still queued and not yet written.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 5, register index width
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when valid&ready
- alu_reg  in  AW  destination register
- alu_data  in  DW  result value
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted when valid&ready
- mem_reg  in  AW  destination register
- mem_data  in  DW  load value
- wb_hold  in  1  1 = do not drain this cycle
- writereg  out  AW  to register file
- writedata  out  DW  to register file
- RegWrite  out  1  to register file write enable
- byp_reg1  in  AW  lookup index 1
- byp_hit1  out  1  queued value exists for byp_reg1
- byp_data1  out  DW  newest queued value for byp_reg1
- byp_reg2  in  AW  lookup index 2
- byp_hit2  out  1  same as port 1, for byp_reg2
- byp_data2  out  DW  same as port 1, for byp_reg2
- empty  out  1  queue holds no entries

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at posedge): count=0, head/tail pointers=0, all entry valids cleared.
  - Outputs then read RegWrite=0, writereg=0, writedata=0, byp_hit*=0, byp_data*=0, empty=1.
  - Reset mid-operation discards all queued entries; no write is issued in the reset cycle.
- Storage: circular buffer of DEPTH entries {reg[AW], data[DW]}, plus count (clog2(DEPTH)+1 bits).
  - Pointers wrap modulo DEPTH.
- Enqueue handshakes: free = DEPTH - count, taken from registered state only; dequeue in the same cycle does not add space.
  - alu_ready = (free >= 1).
  - mem_ready = (free >= 2) || (free >= 1 && !alu_valid).
  - ALU has priority. When both fire in one cycle, the ALU entry goes to tail and the mem entry to tail+1, so the mem result is ordered younger.
- Register 0 filter: a handshake with reg==0 is accepted (ready as above) but not stored and does not consume a slot.
- Drain: when count>0 and wb_hold=0, RegWrite=1 with writereg/writedata = head entry; head advances at posedge.
  - Outputs are combinational from the head entry; they are 0 when empty or when wb_hold=1.
  - Latency: accepted at edge N, earliest write visible on the port in cycle N+1.
- Simultaneous enqueue and dequeue: count += accepted_stored - dequeued; full-at-start still allows dequeue.
- Bypass: byp_hit = any valid entry with reg == byp_reg and byp_reg != 0.
  - byp_data = data of the youngest matching entry, else 0.
  - The head entry being written this cycle still counts as a match, because the register file updates only at the edge.
  - Entries enqueued in the current cycle are not visible until the next cycle.
- empty = (count==0).
- count never exceeds DEPTH and never underflows; either is an assertion failure in the bench.

Decomposition:
- Shared package: AW, DW, REG_ZERO constant, wb_entry_t struct {reg, data}.
- Sub-module: wb_bypass_match, which takes the entry array, valid mask, head pointer and lookup index and returns youngest-match hit/data. It is instantiated twice.

Test Plan:
- Reset then idle: RegWrite=0, empty=1, byp_hit1=0 for byp_reg1=5.
- ALU r3=0x1E alone: next cycle RegWrite=1, writereg=3, writedata=0x1E; the following cycle empty=1.
- Same cycle ALU r4=0x28 and mem r4=0x99 with wb_hold=1: byp_reg1=4 next cycle gives hit=1, data=0x99; after release the writes drain in order 0x28 then 0x99.
- Fill 4 entries with wb_hold=1: alu_ready=0, mem_ready=0.
  - Release hold with alu_valid=1: a dequeue occurs but alu_ready stays 0 that cycle.
  - Next cycle alu_ready=1.
- Writes to r0 (alu_reg=0, data=0xFFFF): accepted, count unchanged, no RegWrite, byp_reg1=0 gives hit=0.
- Reset asserted with 3 entries queued: next cycle empty=1, RegWrite=0, bypass misses for all three registers.
